multisim_client_push_fifo: RTL and testbench

- Successor to the single-register multisim push client: sends words from the local simulation to a multisim server over the client DPI channel.
- Adds a parametrised elastic FIFO, so upstream can push every cycle while the server back-pressures.
- Up to SENDS_PER_CYCLE DPI send attempts per clock, so the FIFO drains faster.
- Synchronous reset, occupancy/idle outputs and statistic counters for the testbench.

---
 rtl/multisim_client_push_fifo.sv | 151 +++++++++++++++
 tb/tb_multisim_client_push_fifo.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/multisim_client_push_fifo.sv
// rtl/multisim_client_push_fifo.sv - elastic push FIFO feeding the multisim client channel
//
// Purpose: buffers upstream words in a FIFO_DEPTH-entry elastic queue and drains
// it towards a multisim server, making up to SENDS_PER_CYCLE send attempts per
// clock. A refused word stays at the head and is retried next cycle unchanged.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   server_name     server to connect to; connection made once non-empty
//   data_rdy        FIFO can take a word this cycle
//   data_vld, data  upstream word handshake
//   fifo_level      current occupancy (0..FIFO_DEPTH)
//   idle            connected, empty, not in reset
//   sent_count      words accepted by the server since reset (wraps)
//   stall_count     cycles whose head send was refused (wraps)

// Behavioural stand-in for the multisim client channel. The server side is a
// queue of accepted words plus an accept policy that the simulation environment
// can steer (accept everything, or accept a limited budget then refuse).
package multisim_client_pkg;
  localparam int MAX_DATA_WIDTH = 1024;

  bit          accept_all    = 1'b1;
  int unsigned accept_budget = 0;
  int unsigned connect_calls = 0;
  int unsigned send_calls    = 0;
  logic [MAX_DATA_WIDTH-1:0] rx_data [$];

  function automatic int connnect_to_server(input string runtime_dir, input string name);
    connect_calls++;
    return (runtime_dir.len() > 0 && name.len() > 0) ? 1 : 0;
  endfunction

  function automatic int multisim_client_send_data(input string name,
                                                   input logic [MAX_DATA_WIDTH-1:0] payload,
                                                   input int width);
    bit ok;
    send_calls++;
    ok = accept_all;
    if (!accept_all && accept_budget != 0) begin
      accept_budget--;
      ok = 1'b1;
    end
    if (name.len() == 0 || width < 1 || width > MAX_DATA_WIDTH) ok = 1'b0;
    if (ok) rx_data.push_back(payload);
    return ok ? 1 : 0;
  endfunction
endpackage

module multisim_client_push_fifo #(
  parameter string SERVER_RUNTIME_DIRECTORY = "../output_top",
  parameter int    DATA_WIDTH               = 64,
  parameter int    FIFO_DEPTH               = 8,
  parameter int    SENDS_PER_CYCLE          = 1,
  parameter int    CNT_WIDTH                = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  string                        server_name,
  output logic                         data_rdy,
  input  logic                         data_vld,
  input  logic [DATA_WIDTH-1:0]        data,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_level,
  output logic                         idle,
  output logic [CNT_WIDTH-1:0]         sent_count,
  output logic [CNT_WIDTH-1:0]         stall_count
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int MW = multisim_client_pkg::MAX_DATA_WIDTH;

  // Everything the drain side updates in one edge, kept together so the
  // side-effecting send sequence is evaluated exactly once per clock.
  typedef struct packed {
    logic [LW-1:0]        rd_ptr;
    logic [CNT_WIDTH-1:0] sent;
    logic [CNT_WIDTH-1:0] stall;
  } drain_t;

  // Connection is sticky: never cleared, not even by rst.
  logic                  connected_q = 1'b0;
  logic [LW-1:0]         wr_ptr_q;
  logic [LW-1:0]         wr_ptr_d;
  drain_t                drain_q;
  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [LW-1:0]         level;
  logic                  push;
  logic                  send_en;

  always_comb begin
    // Extra pointer MSB distinguishes full (level==DEPTH) from empty.
    level    = wr_ptr_q - drain_q.rd_ptr;
    data_rdy = connected_q && !rst && (level < LW'(FIFO_DEPTH));
    idle     = connected_q && !rst && (level == '0);
    push     = data_vld && data_rdy;
    send_en  = connected_q && !rst && (level != '0);
    wr_ptr_d = push ? wr_ptr_q + LW'(1) : wr_ptr_q;
  end

  assign fifo_level  = level;
  assign sent_count  = drain_q.sent;
  assign stall_count = drain_q.stall;

  // Sends from the head in order, only over entries present at the start of
  // the cycle, so a word pushed this edge can never go out on the same edge.
  // The first refusal ends the burst; only a refused head counts as a stall.
  function automatic drain_t drain_step(input drain_t cur, input logic [LW-1:0] lvl);
    drain_t        nxt;
    logic          stop;
    logic [LW-1:0] idx;
    logic [MW-1:0] word;
    int            resp;
    nxt  = cur;
    stop = 1'b0;
    for (int k = 0; k < SENDS_PER_CYCLE; k++) begin
      if (!stop && (LW'(k) < lvl)) begin
        idx  = cur.rd_ptr + LW'(k);
        word = '0;
        word[DATA_WIDTH-1:0] = mem_q[idx[AW-1:0]];
        resp = multisim_client_pkg::multisim_client_send_data(server_name, word, DATA_WIDTH);
        if ((resp & 1) != 0) begin
          nxt.rd_ptr = nxt.rd_ptr + LW'(1);
          nxt.sent   = nxt.sent + CNT_WIDTH'(1);
        end else begin
          stop = 1'b1;
          if (k == 0) nxt.stall = nxt.stall + CNT_WIDTH'(1);
        end
      end
    end
    return nxt;
  endfunction

  always_ff @(posedge clk) begin
    if (!connected_q && server_name != "") begin
      void'(multisim_client_pkg::connnect_to_server(SERVER_RUNTIME_DIRECTORY, server_name));
      connected_q <= 1'b1;
    end
  end

  // Reset drops pointers and counters; stale memory contents become unreachable.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      drain_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      if (send_en) drain_q <= drain_step(drain_q, level);
      if (push) mem_q[wr_ptr_q[AW-1:0]] <= data;
    end
  end
endmodule

// File: tb/tb_multisim_client_push_fifo.sv
// tb/tb_multisim_client_push_fifo.sv - directed scoreboard bench for multisim_client_push_fifo
module tb_multisim_client_push_fifo;
  localparam int DW    = 64;
  localparam int DEPTH = 8;
  localparam int SPC   = 4;
  localparam int CW    = 32;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst;
  string         server_name;
  logic          data_rdy;
  logic          data_vld;
  logic [DW-1:0] data;
  logic [LW-1:0] fifo_level;
  logic          idle;
  logic [CW-1:0] sent_count;
  logic [CW-1:0] stall_count;

  int passed = 0;
  int total  = 0;
  logic [DW-1:0] exp_q [$];
  int unsigned   calls_base;

  always #5 clk = ~clk;

  multisim_client_push_fifo #(
    .SERVER_RUNTIME_DIRECTORY("../output_top"),
    .DATA_WIDTH(DW),
    .FIFO_DEPTH(DEPTH),
    .SENDS_PER_CYCLE(SPC),
    .CNT_WIDTH(CW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .server_name(server_name),
    .data_rdy(data_rdy),
    .data_vld(data_vld),
    .data(data),
    .fifo_level(fifo_level),
    .idle(idle),
    .sent_count(sent_count),
    .stall_count(stall_count)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk_rx_count(input string tag, input int n);
    chk(tag, 64'(multisim_client_pkg::rx_data.size()), 64'(n));
  endtask

  // Pop every word the server received and match it against push order.
  task automatic drain_rx();
    logic [1023:0] w;
    while (multisim_client_pkg::rx_data.size() > 0) begin
      w = multisim_client_pkg::rx_data.pop_front();
      chk("rx_expected", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) chk("rx_word", w[63:0], exp_q.pop_front());
    end
  endtask

  task automatic push_words(input logic [DW-1:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      data     = base + DW'(i);
      data_vld = 1'b1;
      chk("push_rdy", 64'(data_rdy), 64'd1);
      exp_q.push_back(data);
      step();
    end
    data_vld = 1'b0;
  endtask

  initial begin
    rst         = 1'b1;
    server_name = "";
    data_vld    = 1'b0;
    data        = '0;
    step();
    step();
    chk("reset_level", 64'(fifo_level), 64'd0);
    chk("reset_rdy",   64'(data_rdy),   64'd0);
    chk("reset_idle",  64'(idle),       64'd0);
    chk("reset_sent",  64'(sent_count), 64'd0);
    chk("reset_stall", 64'(stall_count), 64'd0);

    // Unconnected: upstream pushes are ignored, no channel traffic.
    rst      = 1'b0;
    data_vld = 1'b1;
    data     = 64'hDEAD;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("unconn_rdy", 64'(data_rdy), 64'd0);
    end
    chk("unconn_level", 64'(fifo_level), 64'd0);
    chk("unconn_connect_calls", 64'(multisim_client_pkg::connect_calls), 64'd0);
    chk("unconn_send_calls", 64'(multisim_client_pkg::send_calls), 64'd0);

    server_name = "srv0";
    step();
    chk("conn_calls", 64'(multisim_client_pkg::connect_calls), 64'd1);
    chk("conn_rdy",   64'(data_rdy), 64'd1);
    chk("conn_idle",  64'(idle),     64'd1);
    data = 64'h5A5A;
    exp_q.push_back(data);
    step();
    data_vld = 1'b0;
    chk("first_level", 64'(fifo_level), 64'd1);
    chk_rx_count("first_no_bypass", 0);
    step();
    drain_rx();
    chk("first_level_empty", 64'(fifo_level), 64'd0);
    chk("first_sent", 64'(sent_count), 64'd1);

    // Back-to-back pushes, each delivered one cycle later.
    for (int i = 1; i <= 3; i++) begin
      data     = DW'(i);
      data_vld = 1'b1;
      exp_q.push_back(data);
      step();
      chk("b2b_level", 64'(fifo_level), 64'd1);
      chk_rx_count("b2b_rx_count", (i > 1) ? 1 : 0);
      drain_rx();
    end
    data_vld = 1'b0;
    step();
    chk_rx_count("b2b_rx_last", 1);
    drain_rx();
    chk("b2b_level_empty", 64'(fifo_level), 64'd0);
    chk("b2b_sent", 64'(sent_count), 64'd4);
    chk("b2b_idle", 64'(idle), 64'd1);

    // Refusing server: fill to full, stalls counted every attempted cycle.
    multisim_client_pkg::accept_all    = 1'b0;
    multisim_client_pkg::accept_budget = 0;
    for (int c = 0; c < 10; c++) begin
      data     = 64'h100 + DW'(c);
      data_vld = 1'b1;
      chk("full_rdy", 64'(data_rdy), 64'(c < DEPTH));
      if (c < DEPTH) exp_q.push_back(data);
      step();
      chk("full_level", 64'(fifo_level), 64'((c + 1 < DEPTH) ? c + 1 : DEPTH));
      chk("full_stall", 64'(stall_count), 64'(c));
    end
    data_vld = 1'b0;
    chk("full_rdy_low", 64'(data_rdy), 64'd0);
    chk_rx_count("full_rx_none", 0);
    multisim_client_pkg::accept_all = 1'b1;
    step();
    chk("release_level", 64'(fifo_level), 64'd4);
    chk("release_rdy",   64'(data_rdy),   64'd1);
    drain_rx();
    step();
    chk("release_level_empty", 64'(fifo_level), 64'd0);
    drain_rx();
    chk("release_sent",  64'(sent_count),  64'd12);
    chk("release_stall", 64'(stall_count), 64'd9);

    // Six preloaded words drain 4 then 2.
    multisim_client_pkg::accept_all = 1'b0;
    push_words(64'h200, 6);
    chk("pre6_level", 64'(fifo_level), 64'd6);
    chk("pre6_stall", 64'(stall_count), 64'd14);
    multisim_client_pkg::accept_all = 1'b1;
    step();
    chk("pre6_level_a", 64'(fifo_level), 64'd2);
    chk_rx_count("pre6_rx_a", 4);
    drain_rx();
    step();
    chk("pre6_level_b", 64'(fifo_level), 64'd0);
    chk_rx_count("pre6_rx_b", 2);
    drain_rx();
    chk("pre6_sent", 64'(sent_count), 64'd18);

    // Partial acceptance: two go, third refused, head retried next cycle.
    multisim_client_pkg::accept_all    = 1'b0;
    multisim_client_pkg::accept_budget = 0;
    push_words(64'h300, 5);
    chk("part_level", 64'(fifo_level), 64'd5);
    chk("part_stall_pre", 64'(stall_count), 64'd18);
    calls_base = multisim_client_pkg::send_calls;
    multisim_client_pkg::accept_budget = 2;
    step();
    chk("part_level_a", 64'(fifo_level), 64'd3);
    chk_rx_count("part_rx_a", 2);
    drain_rx();
    chk("part_sent_a", 64'(sent_count), 64'd20);
    chk("part_stall_a", 64'(stall_count), 64'd18);
    chk("part_calls_a", 64'(multisim_client_pkg::send_calls - calls_base), 64'd3);
    step();
    chk("part_level_b", 64'(fifo_level), 64'd3);
    chk("part_stall_b", 64'(stall_count), 64'd19);
    chk("part_calls_b", 64'(multisim_client_pkg::send_calls - calls_base), 64'd4);
    chk_rx_count("part_rx_b", 0);
    multisim_client_pkg::accept_all = 1'b1;
    step();
    chk_rx_count("part_rx_c", 3);
    drain_rx();
    chk("part_level_c", 64'(fifo_level), 64'd0);
    chk("part_sent_c", 64'(sent_count), 64'd23);

    // Reset with queued words: they are dropped, counters clear.
    multisim_client_pkg::accept_all = 1'b0;
    push_words(64'h400, 5);
    chk("rst_level_pre", 64'(fifo_level), 64'd5);
    chk("rst_stall_pre", 64'(stall_count), 64'd23);
    calls_base = multisim_client_pkg::send_calls;
    rst = 1'b1;
    #1;
    chk("rst_rdy_during", 64'(data_rdy), 64'd0);
    chk("rst_idle_during", 64'(idle), 64'd0);
    step();
    exp_q.delete();
    chk("rst_level", 64'(fifo_level), 64'd0);
    chk("rst_sent",  64'(sent_count), 64'd0);
    chk("rst_stall", 64'(stall_count), 64'd0);
    chk("rst_no_calls", 64'(multisim_client_pkg::send_calls - calls_base), 64'd0);
    chk("rst_rdy_still", 64'(data_rdy), 64'd0);
    rst = 1'b0;
    #1;
    chk("rst_rdy_after", 64'(data_rdy), 64'd1);
    chk("rst_idle_after", 64'(idle), 64'd1);
    multisim_client_pkg::accept_all = 1'b1;
    data     = 64'hAB;
    data_vld = 1'b1;
    exp_q.push_back(data);
    step();
    data_vld = 1'b0;
    chk_rx_count("ab_rx_none", 0);
    step();
    chk_rx_count("ab_rx_one", 1);
    drain_rx();
    chk("ab_sent", 64'(sent_count), 64'd1);
    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
